uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the receive-side counterpart to the transmit path clocked by baudrate_gen. Samples the asynchronous serial line on an oversampling tick (16x baud) supplied by a baudrate_gen instance. Deframes 8N1 characters and presents each byte on a parallel valid/ack interface to the host logic. Flags framing errors and overruns.

Parameters:
OVERSAMPLE, 16, rate_tick pulses per bit period; must be even and >= 4
DATA_BITS, 8, data bits per frame, sent LSB first
SYNC_STAGES, 2, flip-flops in the rxd input synchronizer

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ce  input  1  clock enable; when 0 all state, counters and outputs hold
rate_tick  input  1  one-clk pulse at OVERSAMPLE x baud (from baudrate_gen rateclk)
rxd  input  1  asynchronous serial line, idle high
dout  output  DATA_BITS  received byte
dout_valid  output  1  dout holds an unread byte
dout_ack  input  1  host consumes dout; sampled only while dout_valid=1
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte completed while dout_valid=1
err_clr  input  1  clears frame_err and overrun

Behaviour:
- Reset: state=IDLE, synchronizer stages=1, dout=0, dout_valid=0, frame_err=0, overrun=0, counters=0. Reset wins over ce.
- rxd passes through SYNC_STAGES flops (every clk, gated by ce); rxs = last stage.
- Sub-bit counter (log2 OVERSAMPLE bits) and bit counter advance only on clk with ce=1 and rate_tick=1.
- States:
  - IDLE: sub-counter held 0. On tick with rxs=0 -> START, sub-counter=1.
  - START: on tick with sub-counter=OVERSAMPLE/2-1: if rxs=1 -> IDLE (glitch rejected, no flags); else sub-counter=0, bit counter=0 -> DATA. Otherwise sub-counter++.
  - DATA: on tick with sub-counter=OVERSAMPLE-1: shift rxs into shift register MSB (right shift, LSB first), sub-counter=0; at bit counter=DATA_BITS-1 -> STOP, else bit counter++.
  - STOP: on tick with sub-counter=OVERSAMPLE-1: sample rxs; go to IDLE; shift register -> dout, dout_valid=1 on the next clk edge. If rxs=0, frame_err=1 and byte is still delivered.
- Samples therefore land at bit centres (OVERSAMPLE/2 ticks after the detected falling edge, then every OVERSAMPLE ticks).
- Delivery while dout_valid=1 (unread): dout overwritten with new byte, dout_valid stays 1, overrun=1.
- dout_ack with dout_valid=1 clears dout_valid next edge; simultaneous delivery and ack: new byte loaded, dout_valid stays 1, no overrun.
- err_clr clears both flags next edge; if a flag sets in the same cycle, set wins.
- After IDLE from STOP, a new start bit is accepted immediately (including back-to-back frames with one stop bit).
- rst asserted mid-frame aborts it: partial byte discarded, no flags.
- rate_tick with ce=0 is ignored (not remembered).

Decomposition:
- Shared package uart_pkg: state encoding (IDLE, START, DATA, STOP), default OVERSAMPLE/DATA_BITS constants shared with the transmitter and baudrate_gen.
- One sub-module natural: sync_ff (parameterised SYNC_STAGES bit synchronizer, reset value 1), reusable for other async inputs.

Test Plan:
- rate_tick every clk, ce=1, send 0x55 (start, 1,0,1,0,1,0,1,0, stop) at 16 clk/bit -> dout=0x55, dout_valid rises exactly SYNC_STAGES+1 clks after stop-bit centre tick, frame_err=0.
- Back-to-back 0xA3 then 0x0F, no ack between -> dout=0x0F, dout_valid=1, overrun=1; pulse err_clr -> overrun=0.
- Low glitch on rxd of 4 ticks from idle -> stays IDLE, dout_valid stays 0, no flags.
- Frame 0xFF with stop bit driven low -> dout=0xFF, dout_valid=1, frame_err=1 (sticky until err_clr).
- rate_tick one clk in three, ce toggled low for 10 clks mid-frame (line held stable), send 0x3C -> dout=0x3C; assert rst mid-frame on a second frame -> all outputs 0, next clean frame 0x81 received correctly.
- Ack in same cycle as completion of second byte 0x7E -> dout=0x7E, dout_valid=1, overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to RST_VAL.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the input through the flop chain while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else if (ce) begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver sampling at bit centres on an oversampling tick,
// with a valid/ack byte interface and sticky framing/overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 rate_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ack,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state, state_nxt;
  logic [SUB_W-1:0]     sub_cnt, sub_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic                 shift_en;
  logic                 deliver;
  logic [DATA_BITS-1:0] shreg;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   (rxd),
    .q   (rxs)
  );

  // State register; holds while ce is low, reset wins over ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  // Next-state decode, stepping only on oversampling ticks.
  always_comb begin
    state_nxt = state;
    if (rate_tick) begin
      case (state)
        IDLE:  if (!rxs) state_nxt = START;
        START: if (sub_cnt == SUB_HALF) state_nxt = rxs ? IDLE : DATA;
        DATA:  if (sub_cnt == SUB_LAST && bit_cnt == BIT_LAST) state_nxt = STOP;
        STOP:  if (sub_cnt == SUB_LAST) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counter updates and datapath strobes for the current state.
  always_comb begin
    sub_nxt  = sub_cnt;
    bit_nxt  = bit_cnt;
    shift_en = 1'b0;
    deliver  = 1'b0;
    case (state)
      IDLE: begin
        sub_nxt = '0;
        // Falling edge seen on this tick counts as the first start-bit tick.
        if (rate_tick && !rxs) sub_nxt = SUB_ONE;
      end
      START: begin
        if (rate_tick) begin
          if (sub_cnt == SUB_HALF) begin
            sub_nxt = '0;
            bit_nxt = '0;
          end else begin
            sub_nxt = sub_cnt + SUB_ONE;
          end
        end
      end
      DATA: begin
        if (rate_tick) begin
          if (sub_cnt == SUB_LAST) begin
            sub_nxt  = '0;
            shift_en = 1'b1;
            if (bit_cnt != BIT_LAST) bit_nxt = bit_cnt + BIT_ONE;
          end else begin
            sub_nxt = sub_cnt + SUB_ONE;
          end
        end
      end
      STOP: begin
        if (rate_tick) begin
          if (sub_cnt == SUB_LAST) begin
            sub_nxt = '0;
            deliver = 1'b1;
          end else begin
            sub_nxt = sub_cnt + SUB_ONE;
          end
        end
      end
      default: begin
        sub_nxt = '0;
        bit_nxt = '0;
      end
    endcase
  end

  // Sub-bit and bit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt <= '0;
      bit_cnt <= '0;
    end else if (ce) begin
      sub_cnt <= sub_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  // Deserializer: bits arrive LSB first, so shift right from the MSB.
  always_ff @(posedge clk) begin
    if (ce && shift_en) begin
      shreg <= {rxs, shreg[DATA_BITS-1:1]};
    end
  end

  // Output byte register, loaded when the stop bit is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (ce && deliver) begin
      dout <= shreg;
    end
  end

  // Valid handshake and sticky error flags; a new set beats err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (ce) begin
      if (deliver) begin
        dout_valid <= 1'b1;
      end else if (dout_ack && dout_valid) begin
        dout_valid <= 1'b0;
      end
      frame_err <= (deliver && !rxs) || (frame_err && !err_clr);
      // An ack landing with the new byte means the old one was consumed.
      overrun   <= (deliver && dout_valid && !dout_ack) || (overrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven on rxd, tick/ce patterns are
// generated alongside, and outputs are compared with hand-derived values.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int SS = 2;
  // Edges from the edge that launches the start bit to dout_valid rising:
  // SS synchronizer flops, one edge to detect, OS/2-1 to the start centre,
  // then DB data bits plus the stop bit at OS ticks each (tick every clk).
  localparam int LAT = SS + 1 + (OS / 2 - 1) + (DB + 1) * OS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b1;
  logic          rate_tick = 1'b0;
  logic          rxd = 1'b1;
  logic [DB-1:0] dout;
  logic          dout_valid;
  logic          dout_ack = 1'b0;
  logic          frame_err;
  logic          overrun;
  logic          err_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int edge_cnt   = 0;
  int rise_edge  = -1;
  int tick_div   = 1;
  int phase      = 0;
  int ce_off     = 0;
  int ce_low_at  = -1;
  int ack_target = -1;
  int start_e    = 0;
  bit ack_req    = 1'b0;
  bit clr_req    = 1'b0;
  bit rst_req    = 1'b1;
  bit last_eff   = 1'b0;
  bit prev_v     = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(
    .OVERSAMPLE  (OS),
    .DATA_BITS   (DB),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .rate_tick  (rate_tick),
    .rxd        (rxd),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ack   (dout_ack),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample outputs on the falling edge.
  task automatic step();
    if (edge_cnt + 1 == ce_low_at) ce_off = 10;
    rate_tick = (phase == 0);
    ce        = (ce_off == 0);
    dout_ack  = ack_req || (edge_cnt + 1 == ack_target);
    err_clr   = clr_req;
    rst       = rst_req;
    @(posedge clk);
    edge_cnt++;
    last_eff = rate_tick && ce;
    phase    = (phase + 1 >= tick_div) ? 0 : phase + 1;
    if (ce_off > 0) ce_off--;
    @(negedge clk);
    if (dout_valid && !prev_v) rise_edge = edge_cnt;
    prev_v = dout_valid;
  endtask

  task automatic ticks(input int n);
    int c = 0;
    while (c < n) begin
      step();
      if (last_eff) c++;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rxd = b[i];
      ticks(OS);
    end
    if (stop_bit) begin
      rxd = 1'b1;
      ticks(OS);
    end else begin
      // Release the low stop bit shortly after its centre so the release is
      // rejected as a glitch rather than taken as a new start bit.
      rxd = 1'b0;
      ticks(OS / 2 + 2);
      rxd = 1'b1;
      ticks(OS / 2 - 2);
    end
    rxd = 1'b1;
  endtask

  task automatic pulse_ack();
    ack_req = 1'b1;
    step();
    ack_req = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    rst_req = 1'b1;
    repeat (3) step();
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst_req = 1'b0;
    repeat (4) step();

    // Single clean byte, tick every clock.
    start_e   = edge_cnt;
    rise_edge = -1;
    send_frame(8'h55, 1'b1);
    check("t1_dout", 32'(dout), 32'h55);
    check("t1_valid", 32'(dout_valid), 32'h1);
    check("t1_frame_err", 32'(frame_err), 32'h0);
    check("t1_latency", 32'(rise_edge - start_e), 32'(LAT));
    pulse_ack();
    check("t1_ack_clears", 32'(dout_valid), 32'h0);

    // Back-to-back frames without ack produce an overrun.
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    check("t2_dout", 32'(dout), 32'h0F);
    check("t2_valid", 32'(dout_valid), 32'h1);
    check("t2_overrun", 32'(overrun), 32'h1);
    check("t2_frame_err", 32'(frame_err), 32'h0);
    pulse_clr();
    check("t2_clr_overrun", 32'(overrun), 32'h0);
    check("t2_valid_kept", 32'(dout_valid), 32'h1);
    pulse_ack();

    // Short low glitch from idle is rejected.
    rxd = 1'b0;
    ticks(4);
    rxd = 1'b1;
    ticks(40);
    check("t3_valid", 32'(dout_valid), 32'h0);
    check("t3_dout_kept", 32'(dout), 32'h0F);
    check("t3_frame_err", 32'(frame_err), 32'h0);
    check("t3_overrun", 32'(overrun), 32'h0);

    // Low stop bit: byte delivered, sticky frame error.
    send_frame(8'hFF, 1'b0);
    check("t4_dout", 32'(dout), 32'hFF);
    check("t4_valid", 32'(dout_valid), 32'h1);
    check("t4_frame_err", 32'(frame_err), 32'h1);
    ticks(30);
    check("t4_sticky", 32'(frame_err), 32'h1);
    check("t4_overrun", 32'(overrun), 32'h0);
    pulse_clr();
    check("t4_clr", 32'(frame_err), 32'h0);
    pulse_ack();

    // Sparse ticks and a ce-low window mid-frame.
    tick_div  = 3;
    phase     = 0;
    ce_low_at = edge_cnt + 200;
    send_frame(8'h3C, 1'b1);
    check("t5_dout", 32'(dout), 32'h3C);
    check("t5_valid", 32'(dout_valid), 32'h1);
    check("t5_frame_err", 32'(frame_err), 32'h0);

    // Reset in the middle of a frame, with ce low to show reset dominates.
    rxd = 1'b0;
    ticks(OS);
    rxd = 1'b1;
    ticks(OS);
    rxd = 1'b0;
    ticks(OS / 2);
    ce_off  = 4;
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    rxd = 1'b1;
    check("t5_rst_dout", 32'(dout), 32'h0);
    check("t5_rst_valid", 32'(dout_valid), 32'h0);
    check("t5_rst_frame_err", 32'(frame_err), 32'h0);
    check("t5_rst_overrun", 32'(overrun), 32'h0);
    ticks(40);
    send_frame(8'h81, 1'b1);
    check("t5_after_rst_dout", 32'(dout), 32'h81);
    check("t5_after_rst_valid", 32'(dout_valid), 32'h1);
    check("t5_after_rst_flags", 32'({frame_err, overrun}), 32'h0);
    pulse_ack();

    // Ack coinciding with delivery of the second byte: no overrun.
    tick_div = 1;
    phase    = 0;
    ticks(20);
    send_frame(8'h12, 1'b1);
    check("t6_first_dout", 32'(dout), 32'h12);
    check("t6_first_valid", 32'(dout_valid), 32'h1);
    ack_target = edge_cnt + LAT;
    send_frame(8'h7E, 1'b1);
    ack_target = -1;
    check("t6_dout", 32'(dout), 32'h7E);
    check("t6_valid", 32'(dout_valid), 32'h1);
    check("t6_overrun", 32'(overrun), 32'h0);
    pulse_ack();
    check("t6_ack_clears", 32'(dout_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
